// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, drives the inst_mem address and fills the IF/ID register.
// Supports redirect with flush, hazard stall, HALT detection and a saturating delivered-instruction count.
//
// state   | meaning
// --------+---------------------------------------------------------------
// S_RUN   | fetching sequentially; each unstalled edge delivers one instr
// S_HALTED| HALT latched; PC frozen at the HALT address, bubbles only
module fetch_stage #(
  parameter logic [7:0]  RESET_PC  = 8'h00,
  parameter logic [3:0]  HALT_OP   = 4'hF,
  parameter logic [15:0] NOP_INSTR = 16'h0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        redirect,
  input  logic [7:0]  redirect_target,
  input  logic [15:0] Instruction,
  output logic [7:0]  Address,
  output logic [15:0] if_id_instr,
  output logic [7:0]  if_id_pc,
  output logic [7:0]  if_id_pc_plus2,
  output logic        if_id_valid,
  output logic        halted,
  output logic [15:0] fetch_count
);

  typedef enum logic {S_RUN = 1'b0, S_HALTED = 1'b1} state_t;

  state_t      r_state;
  logic [7:0]  r_pc;
  logic [15:0] r_instr;
  logic [7:0]  r_if_pc;
  logic [7:0]  r_if_pc2;
  logic        r_valid;
  logic [15:0] r_count;

  state_t      w_state;
  logic [7:0]  w_pc;
  logic [15:0] w_instr;
  logic [7:0]  w_if_pc;
  logic [7:0]  w_if_pc2;
  logic        w_valid;
  logic [15:0] w_count;

  logic [7:0]  w_pc_plus2;
  logic [7:0]  w_target;
  logic        w_is_halt;

  assign w_pc_plus2 = r_pc + 8'd2;
  // Redirect targets are always halfword aligned.
  assign w_target   = redirect_target & 8'hFE;
  assign w_is_halt  = (Instruction[15:12] == HALT_OP);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_RUN;
      r_pc     <= RESET_PC;
      r_instr  <= NOP_INSTR;
      r_if_pc  <= 8'h00;
      r_if_pc2 <= 8'h00;
      r_valid  <= 1'b0;
      r_count  <= 16'h0000;
    end else begin
      r_state  <= w_state;
      r_pc     <= w_pc;
      r_instr  <= w_instr;
      r_if_pc  <= w_if_pc;
      r_if_pc2 <= w_if_pc2;
      r_valid  <= w_valid;
      r_count  <= w_count;
    end
  end

  always_comb begin
    w_state  = r_state;
    w_pc     = r_pc;
    w_instr  = r_instr;
    w_if_pc  = r_if_pc;
    w_if_pc2 = r_if_pc2;
    w_valid  = r_valid;
    w_count  = r_count;
    if (redirect) begin
      // A redirect squashes whatever was fetched, including a speculative HALT.
      w_state = S_RUN;
      w_pc    = w_target;
      w_instr = NOP_INSTR;
      w_valid = 1'b0;
    end else if (stall) begin
      w_state = r_state;
    end else if (r_state == S_HALTED) begin
      w_instr = NOP_INSTR;
      w_valid = 1'b0;
    end else begin
      w_instr  = Instruction;
      w_if_pc  = r_pc;
      w_if_pc2 = w_pc_plus2;
      w_valid  = 1'b1;
      if (r_count != 16'hFFFF) w_count = r_count + 16'd1;
      if (w_is_halt) w_state = S_HALTED;
      else           w_pc    = w_pc_plus2;
    end
  end

  assign Address        = r_pc;
  assign if_id_instr    = r_instr;
  assign if_id_pc       = r_if_pc;
  assign if_id_pc_plus2 = r_if_pc2;
  assign if_id_valid    = r_valid;
  assign halted         = (r_state == S_HALTED);
  assign fetch_count    = r_count;

endmodule
